// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Sequencing controller for an RV64M divide/remainder unit.
//                Accepts one request at a time, resolves divide-by-zero,
//                signed overflow and repeat-operand (cache hit) cases
//                without starting the divider core, otherwise drives the
//                iterative core and formats its quotient/remainder into
//                the final architectural result.
//
//  Ports
//    clk, reset             : clock, synchronous active-high reset
//    in_valid / in_ready    : request handshake (ready only when idle)
//    op[2:0]                : [0]=unsigned, [1]=return remainder, [2]=word op
//    a, b                   : 64-bit dividend and divisor
//    flush                  : abort any in-flight operation
//    out_valid / out_ready  : result handshake
//    result                 : 64-bit formatted result (0 when not valid)
//    core_a/core_b/core_signed/core_valid : request to the divider core
//    core_quot/core_rem/core_done         : one-cycle reply from the core
//
//  Revision    : 1.0  initial release
// ============================================================================
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [63:0] core_a,
    output logic [63:0] core_b,
    output logic        core_signed,
    output logic        core_valid,
    input  logic [63:0] core_quot,
    input  logic [63:0] core_rem,
    input  logic        core_done
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_CALC      = 2'd1;
    localparam logic [1:0]  c_HOLD      = 2'd2;
    localparam logic [63:0] c_INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    // Latched request (operands are held here in extended form, which also
    // keeps the core inputs stable for the whole calculation).
    logic        r_sel_rem;
    logic        r_word;
    logic [63:0] r_ea;
    logic [63:0] r_eb;
    logic        r_signed;
    logic [63:0] r_quot;
    logic [63:0] r_rem;

    // One-entry result cache
    logic        r_cache_valid;
    logic [63:0] r_cache_a;
    logic [63:0] r_cache_b;
    logic        r_cache_signed;
    logic [63:0] r_cache_quot;
    logic [63:0] r_cache_rem;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_signed;
    logic        w_word;
    logic [63:0] w_ea;
    logic [63:0] w_eb;
    logic        w_div_zero;
    logic        w_overflow;
    logic        w_hit;
    logic        w_fast;
    logic [63:0] w_fast_quot;
    logic [63:0] w_fast_rem;
    logic        w_accept;
    logic        w_core_finish;
    logic [63:0] w_sel;

    assign w_signed = ~op[0];
    assign w_word   = op[2];

    always_comb begin
        w_ea = a;
        w_eb = b;
        if (w_word) begin
            if (w_signed) begin
                w_ea = {{32{a[31]}}, a[31:0]};
                w_eb = {{32{b[31]}}, b[31:0]};
            end else begin
                w_ea = {32'd0, a[31:0]};
                w_eb = {32'd0, b[31:0]};
            end
        end
    end

    // Extension never turns a non-zero low word into zero, so testing the
    // extended divisor covers both the 64-bit and word forms.
    assign w_div_zero = (w_eb == 64'd0);

    // The word overflow case is tested on the raw low words; after sign
    // extension the dividend is no longer the 64-bit minimum value.
    assign w_overflow = w_signed &&
                        (w_word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                                : ((a == c_INT64_MIN) && (b == c_ALL_ONES)));

    assign w_hit = r_cache_valid && (r_cache_a == w_ea) && (r_cache_b == w_eb) &&
                   (r_cache_signed == w_signed);

    assign w_fast = w_div_zero || w_overflow || w_hit;

    always_comb begin
        w_fast_quot = r_cache_quot;
        w_fast_rem  = r_cache_rem;
        if (w_div_zero) begin
            w_fast_quot = c_ALL_ONES;
            w_fast_rem  = w_ea;
        end else if (w_overflow) begin
            w_fast_quot = w_ea;
            w_fast_rem  = 64'd0;
        end
    end

    // Flush blocks acceptance even though in_ready is still high.
    assign w_accept      = in_valid && (r_state == c_IDLE) && !flush;
    assign w_core_finish = (r_state == c_CALC) && core_done && !flush;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        w_next_state = w_fast ? c_HOLD : c_CALC;
                    end
                end
                c_CALC: begin
                    if (core_done) begin
                        w_next_state = c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (out_ready) begin
                        w_next_state = c_IDLE;
                    end
                end
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and cache registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_rem      <= 1'b0;
            r_word         <= 1'b0;
            r_ea           <= 64'd0;
            r_eb           <= 64'd0;
            r_signed       <= 1'b0;
            r_quot         <= 64'd0;
            r_rem          <= 64'd0;
            r_cache_valid  <= 1'b0;
            r_cache_a      <= 64'd0;
            r_cache_b      <= 64'd0;
            r_cache_signed <= 1'b0;
            r_cache_quot   <= 64'd0;
            r_cache_rem    <= 64'd0;
        end else begin
            if (w_accept) begin
                r_sel_rem <= op[1];
                r_word    <= w_word;
                r_ea      <= w_ea;
                r_eb      <= w_eb;
                r_signed  <= w_signed;
                // Only meaningful for fast cases; the core reply replaces
                // these on the slow path.
                r_quot    <= w_fast_quot;
                r_rem     <= w_fast_rem;
            end
            if (w_core_finish) begin
                r_quot         <= core_quot;
                r_rem          <= core_rem;
                r_cache_valid  <= 1'b1;
                r_cache_a      <= r_ea;
                r_cache_b      <= r_eb;
                r_cache_signed <= r_signed;
                r_cache_quot   <= core_quot;
                r_cache_rem    <= core_rem;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    assign w_sel = r_sel_rem ? r_rem : r_quot;

    always_comb begin
        in_ready    = (r_state == c_IDLE);
        out_valid   = (r_state == c_HOLD);
        core_valid  = (r_state == c_CALC);
        core_a      = r_ea;
        core_b      = r_eb;
        core_signed = r_signed;
        result      = 64'd0;
        if (r_state == c_HOLD) begin
            // Word results are always sign-extended, signed or not.
            result = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Self-checking bench for div_ctrl. A transaction-level model
//                (arithmetic divider, fast-case rules, one-entry cache)
//                sets the expected outputs; a negedge process compares the
//                DUT against them every cycle, and directed steps pin
//                hand-computed literal results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_ctrl;

    localparam logic [63:0] c_INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_ONES      = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready, core_done;
    logic [2:0]  op;
    logic [63:0] a, b, core_quot, core_rem;
    logic        in_ready, out_valid, core_signed, core_valid;
    logic [63:0] result, core_a, core_b;

    div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_signed(core_signed),
        .core_valid (core_valid),
        .core_quot  (core_quot),
        .core_rem   (core_rem),
        .core_done  (core_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs, maintained by the stimulus/model
    bit          chk_on = 0;
    logic        exp_in_ready, exp_out_valid, exp_core_valid, exp_core_signed;
    logic [63:0] exp_result, exp_core_a, exp_core_b;

    // Model of the result cache
    bit          mc_valid = 0;
    logic [63:0] mc_a, mc_b, mc_q, mc_r;
    bit          mc_s;

    // Optional literal check of the core request at T+1
    bit          lit_core_en = 0;
    logic [63:0] lit_core_a, lit_core_b;
    logic        lit_core_s;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    function automatic logic [63:0] ext(input logic [2:0] o, input logic [63:0] x);
        if (!o[2]) return x;
        if (o[0]) return {32'd0, x[31:0]};
        return {{32{x[31]}}, x[31:0]};
    endfunction

    function automatic logic [63:0] finalize(input logic [2:0] o, input logic [63:0] q,
                                             input logic [63:0] r);
        logic [63:0] s;
        s = o[1] ? r : q;
        return o[2] ? {{32{s[31]}}, s[31:0]} : s;
    endfunction

    // Ideal divider core: truncating division on the extended operands
    task automatic core_model(input logic [63:0] ea, input logic [63:0] eb, input bit sgn,
                              output logic [63:0] q, output logic [63:0] r);
        if (sgn) begin
            q = $signed(ea) / $signed(eb);
            r = $signed(ea) % $signed(eb);
        end else begin
            q = ea / eb;
            r = ea % eb;
        end
    endtask

    task automatic set_idle();
        exp_in_ready   = 1'b1;
        exp_out_valid  = 1'b0;
        exp_core_valid = 1'b0;
        exp_result     = 64'd0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_in_ready});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_out_valid});
            chk("core_valid", {63'd0, core_valid}, {63'd0, exp_core_valid});
            chk("result", result, exp_result);
            if (exp_core_valid) begin
                chk("core_a", core_a, exp_core_a);
                chk("core_b", core_b, exp_core_b);
                chk("core_signed", {63'd0, core_signed}, {63'd0, exp_core_signed});
            end
        end
    end

    // One request from issue to release. flush_at>0 aborts the calculation
    // that many cycles into CALC (with a simultaneous core_done);
    // rst_hold replaces the out_ready release by a reset pulse.
    task automatic do_op(input logic [2:0] o, input logic [63:0] xa, input logic [63:0] xb,
                         input int lat, input int hold, input int flush_at, input bit rst_hold,
                         input logic [63:0] lit);
        logic [63:0] ea, eb, q, r;
        bit sgn, fast;
        ea   = ext(o, xa);
        eb   = ext(o, xb);
        sgn  = !o[0];
        fast = 1;
        if (eb == 64'd0) begin
            q = c_ONES;
            r = ea;
        end else if (sgn && (o[2] ? (xa[31:0] == 32'h8000_0000 && xb[31:0] == 32'hFFFF_FFFF)
                                  : (xa == c_INT64_MIN && xb == c_ONES))) begin
            q = ea;
            r = 64'd0;
        end else if (mc_valid && mc_a == ea && mc_b == eb && mc_s == sgn) begin
            q = mc_q;
            r = mc_r;
        end else begin
            fast = 0;
            core_model(ea, eb, sgn, q, r);
        end

        in_valid = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'd0; a = 64'd0; b = 64'd0;
        exp_in_ready = 1'b0;
        if (!fast) begin
            exp_core_valid  = 1'b1;
            exp_core_a      = ea;
            exp_core_b      = eb;
            exp_core_signed = sgn;
            if (lit_core_en) begin
                chk("lit_core_a", core_a, lit_core_a);
                chk("lit_core_b", core_b, lit_core_b);
                chk("lit_core_signed", {63'd0, core_signed}, {63'd0, lit_core_s});
                lit_core_en = 0;
            end
            repeat (((flush_at > 0) ? flush_at : lat) - 1) begin @(posedge clk); #1; end
            core_done = 1'b1; core_quot = q; core_rem = r;
            flush = (flush_at > 0);
            @(posedge clk); #1;
            core_done = 1'b0; flush = 1'b0; core_quot = 64'd0; core_rem = 64'd0;
            exp_core_valid = 1'b0;
            if (flush_at > 0) begin
                set_idle();
                chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
                chk("flush_core_valid", {63'd0, core_valid}, 64'd0);
                return;
            end
            mc_valid = 1; mc_a = ea; mc_b = eb; mc_s = sgn; mc_q = q; mc_r = r;
        end
        exp_out_valid = 1'b1;
        exp_result    = finalize(o, q, r);
        chk("lit_result", result, lit);
        repeat (hold) begin @(posedge clk); #1; end
        if (rst_hold) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            set_idle();
            mc_valid = 0;
            chk("reset_hold_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
            out_ready = 1'b1;
            chk("in_ready_in_release_cycle", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            out_ready = 1'b0;
            set_idle();
            chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; core_done = 1'b0;
        op = 3'd0; a = 64'd0; b = 64'd0; core_quot = 64'd0; core_rem = 64'd0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_core_valid", {63'd0, core_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk_on = 1;

        // DIV -7/2 through the core, then REM of the same operands hits
        do_op(3'b000, -64'sd7, 64'd2, 64, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'b010, -64'sd7, 64'd2, 1, 0, 0, 0, c_ONES);
        // Divide by zero
        do_op(3'b001, 64'd5, 64'd0, 1, 0, 0, 0, c_ONES);
        do_op(3'b111, 64'h1_8000_0005, 64'd0, 1, 0, 0, 0, 64'hFFFF_FFFF_8000_0005);
        // Signed overflow
        do_op(3'b000, c_INT64_MIN, c_ONES, 1, 0, 0, 0, c_INT64_MIN);
        do_op(3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 1, 0, 0, 0, 64'hFFFF_FFFF_8000_0000);
        do_op(3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 1, 0, 0, 0, 64'd0);
        // DIVUW zero-extends into the core
        lit_core_en = 1; lit_core_a = 64'hA; lit_core_b = 64'd3; lit_core_s = 1'b0;
        do_op(3'b101, 64'hFFFF_FFFF_0000_000A, 64'd3, 8, 0, 0, 0, 64'd3);

        // Flush with in_valid and a stray core_done while idle: nothing accepted
        in_valid = 1'b1; flush = 1'b1; core_done = 1'b1; op = 3'b000; a = 64'd9; b = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; core_done = 1'b0;
        chk("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_idle_core_valid", {63'd0, core_valid}, 64'd0);

        // Flush 10 cycles into CALC with core_done, then re-issue (no hit)
        do_op(3'b000, 64'd100, 64'd7, 12, 0, 10, 0, 64'd0);
        do_op(3'b000, 64'd100, 64'd7, 12, 5, 0, 0, 64'd14);
        // Hit held in HOLD and killed by reset; cache must be invalidated
        do_op(3'b010, 64'd100, 64'd7, 1, 2, 0, 1, 64'd2);
        do_op(3'b010, 64'd100, 64'd7, 3, 0, 0, 0, 64'd2);
        // Unsigned 64-bit and signed word paths through the core
        do_op(3'b001, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 20, 1, 0, 0, 64'h0FFF_FFFF_FFFF_FFFF);
        do_op(3'b110, 64'h0000_0000_FFFF_FFF9, 64'h1_0000_0002, 4, 0, 0, 0, c_ONES);
        do_op(3'b011, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 3, 0, 0, 0, 64'd0);

        repeat (2) @(posedge clk);
        #1;
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
